// File: rtl/div_seq.sv
// Sequential restoring radix-2 divider, signed or unsigned, one quotient bit per clock.
// Result is {remainder, quotient} and is held while start_i stays high in END.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 div_by_zero_o
);

    // state  | meaning
    // IDLE   | waiting for start_i
    // BYZERO | divisor was zero, one cycle to publish the flagged zero result
    // ON     | WIDTH restoring steps, then sign correction on the extra cycle
    // END    | result published, held until start_i drops
    typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] divisor_q;
    logic             neg_quot;
    logic             neg_rem;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   trial;
    logic             borrow;

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    always_comb begin
        mag_a = (signed_div_i && opdata1_i[WIDTH-1]) ? neg(opdata1_i) : opdata1_i;
        mag_b = (signed_div_i && opdata2_i[WIDTH-1]) ? neg(opdata2_i) : opdata2_i;
        trial = {rem_q, quot_q[WIDTH-1]} - {1'b0, divisor_q};
        // The shifted remainder is below twice the divisor, so bit WIDTH of the
        // wrapped difference is set exactly when the subtract borrows.
        borrow = trial[WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            quot_q        <= '0;
            rem_q         <= '0;
            divisor_q     <= '0;
            neg_quot      <= 1'b0;
            neg_rem       <= 1'b0;
            result_o      <= '0;
            ready_o       <= 1'b0;
            busy_o        <= 1'b0;
            div_by_zero_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i && !annul_i) begin
                        quot_q    <= mag_a;
                        divisor_q <= mag_b;
                        rem_q     <= '0;
                        cnt       <= '0;
                        neg_quot  <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_rem   <= signed_div_i && opdata1_i[WIDTH-1];
                        busy_o    <= 1'b1;
                        state     <= (opdata2_i == '0) ? S_BYZERO : S_ON;
                    end
                end
                S_BYZERO: begin
                    busy_o <= 1'b0;
                    if (annul_i) begin
                        state <= S_IDLE;
                    end else begin
                        result_o      <= '0;
                        div_by_zero_o <= 1'b1;
                        state         <= S_END;
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                    end else if (cnt == CW'(WIDTH)) begin
                        result_o      <= {neg_rem  ? neg(rem_q)  : rem_q,
                                          neg_quot ? neg(quot_q) : quot_q};
                        div_by_zero_o <= 1'b0;
                        busy_o        <= 1'b0;
                        state         <= S_END;
                    end else begin
                        rem_q  <= borrow ? {rem_q[WIDTH-2:0], quot_q[WIDTH-1]} : trial[WIDTH-1:0];
                        quot_q <= {quot_q[WIDTH-2:0], ~borrow};
                        cnt    <= cnt + CW'(1);
                    end
                end
                S_END: begin
                    if (!start_i) begin
                        ready_o       <= 1'b0;
                        result_o      <= '0;
                        div_by_zero_o <= 1'b0;
                        state         <= S_IDLE;
                    end else begin
                        ready_o <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 WIDTH, default 32: operand width in bits; SHALL be supported for any even value 8..64.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-low.
REQ-004 signed_div_i  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start_i.
REQ-005 opdata1_i  input  WIDTH  dividend; sampled with start_i.
REQ-006 opdata2_i  input  WIDTH  divisor; sampled with start_i.
REQ-007 start_i  input  1  request a divide; must stay high until ready_o is seen.
REQ-008 annul_i  input  1  cancel the operation in flight (pipeline flush).
REQ-009 result_o  output  2*WIDTH  {remainder, quotient}; upper half goes to HI, lower half to LO.
REQ-010 ready_o  output  1  result_o valid.
REQ-011 busy_o  output  1  divide in progress; EX uses it to stall.
REQ-012 div_by_zero_o  output  1  result_o came from a zero divisor.

Function
REQ-013 The FSM SHALL have four states: IDLE, BYZERO, ON, END.
REQ-014 In IDLE with start_i=1 and annul_i=0, the block SHALL latch the operands and sign mode, clear the step counter, and go to BYZERO if opdata2_i==0, else to ON.
REQ-015 In IDLE with start_i=0 or annul_i=1, the block SHALL stay in IDLE.
REQ-016 BYZERO SHALL go to END after one cycle with result 0 and div_by_zero flag set.
REQ-017 ON SHALL use restoring radix-2 division and produce one quotient bit per cycle for WIDTH cycles.
REQ-018 In each ON step, the block SHALL form a (WIDTH+1)-bit trial subtract of the divisor magnitude from the partial remainder.
REQ-019 In each ON step, if the trial subtract borrows, the block SHALL shift in 0 and keep the remainder; otherwise it SHALL shift in 1 and keep the difference.
REQ-020 On the cycle after step WIDTH, ON SHALL apply the sign correction, load the result register and go to END.
REQ-021 When signed_div_i=1, each negative operand SHALL be replaced by its magnitude (negated and treated as unsigned) before stepping.
REQ-022 When signed_div_i=1, the quotient SHALL be negated if the operand signs differ, and the remainder SHALL take the dividend's sign.
REQ-023 Signed MIN/-1 SHALL give quotient MIN (wrap-around) and remainder 0, with no flag.
REQ-024 With annul_i=1 in BYZERO or ON, the block SHALL return to IDLE on the next edge, keep ready_o low and discard partial results.
REQ-025 In END, ready_o SHALL be 1 and result_o SHALL hold the result.
REQ-026 In END, the block SHALL stay while start_i=1 and go to IDLE the cycle after start_i=0.
REQ-027 annul_i SHALL be ignored in END.
REQ-028 Latency: ready_o SHALL first be high WIDTH+2 edges after the edge that samples start_i in the non-zero-divisor case, and 2 edges after it for a zero divisor.
REQ-029 busy_o SHALL be high exactly in BYZERO and ON.
REQ-030 Outside END, ready_o SHALL be 0, result_o SHALL be 0 and div_by_zero_o SHALL be 0.
REQ-031 ready_o, result_o and div_by_zero_o SHALL be registered, with no combinational path from inputs.
REQ-032 Input changes after the start sample SHALL NOT affect the operation in flight.
REQ-033 start_i rising in any state except IDLE SHALL be ignored.

Reset
REQ-034 rst=0 SHALL immediately, without a clock edge, force state IDLE, counter 0, ready_o=0, busy_o=0, div_by_zero_o=0 and result_o=0.
REQ-035 Reset asserted mid-operation SHALL abandon the operation; after release the block SHALL accept a new start.
REQ-036 The first start after reset release SHALL be honoured on the first rising edge where rst=1.

Verification
REQ-037 Unsigned divide, WIDTH=32: 100/7 -> result_o={0x00000002, 0x0000000E}, ready_o high exactly 34 edges after the start edge, busy_o high for 33 cycles before it.
REQ-038 Signed divide: -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001; 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-039 Zero divisor: 5/0 -> ready_o after 2 edges, div_by_zero_o=1, result_o=0, busy_o high for 1 cycle.
REQ-040 Annul: annul_i pulsed 10 cycles into ON -> IDLE next edge, ready_o never rises; a following 9/3 gives {0, 3} with full latency.
REQ-041 Handshake: start_i held 5 cycles in END -> ready_o and result_o stable for all 5; drop start_i -> ready_o=0 and result_o=0 one edge later; start_i held high across IDLE after END -> new operation starts.
REQ-042 Reset: rst=0 asserted between edges mid-ON -> outputs zero before the next edge; WIDTH=8 build: 0xFF/0x10 unsigned -> {0x0F, 0x0F} after 10 edges.
